button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Multi-channel input conditioner for the clock's adjust/mode buttons. It is the parametrised successor to the fixed 3-flop AND smoother.
- Per channel it provides:
  - a 2-flop synchroniser;
  - a symmetric, tick-counted debounce filter;
  - one-cycle press and release pulses;
  - hold-to-auto-repeat, so a held adjust button steps the time repeatedly.
- Sits between the raw button pins and the time-setting logic. The action output replaces the old single-level adjust signal.

Parameters:
- N_CH, 4: number of independent button channels (>=1).
- STABLE_TICKS, 4: consecutive disagreeing ticks required before the debounced level changes (>=1).
- REPEAT_DELAY, 8: ticks a press must be held before the first repeat pulse. 0 disables auto-repeat.
- REPEAT_PERIOD, 3: ticks between subsequent repeat pulses (>=1).
- ACTIVE_LOW_IN, 0: 1 inverts btn_in before synchronisation (for pull-up buttons).

Ports:
- clk, in, 1: system clock; all state updates on posedge.
- clear_n, in, 1: synchronous active-low reset.
- tick, in, 1: time-base enable; debounce and repeat counters advance only in cycles where tick=1.
- btn_in, in, N_CH: raw asynchronous button inputs.
- level, out, N_CH: debounced level (1 = pressed).
- press, out, N_CH: one-cycle pulse on a debounced 0->1 transition.
- release, out, N_CH: one-cycle pulse on a debounced 1->0 transition.
- repeat_pulse, out, N_CH: one-cycle auto-repeat pulse.
- action, out, N_CH: press | repeat_pulse (the adjust-step strobe).

Behaviour:
- Reset:
  - Sampling: on any posedge with clear_n=0, every register clears.
  - Cleared state: sync flops, level, press, release, repeat_pulse, all counters =0; FSM = IDLE.
  - Effect: reset overrides everything, including mid-count and mid-repeat. Normal operation resumes on the first edge with clear_n=1.
- Input polarity: the optional inversion is applied before the sync flops, so the reset value 0 always means "not pressed".
- Synchroniser:
  - s1 <= in; s2 <= s1.
  - Only s2 feeds the filter.
- Debounce (per channel), counter width clog2(STABLE_TICKS+1):
  - s2==level: cnt <= 0 regardless of tick.
  - s2!=level and tick=1, cnt==STABLE_TICKS-1: level <= s2; cnt <= 0.
  - s2!=level and tick=1, otherwise: cnt++.
  - s2!=level and tick=0: cnt holds.
  - Consequence: a glitch shorter than STABLE_TICKS ticks never changes level.
- Edge pulses:
  - press and release are registered and assert in the cycle after the edge at which level changes, for exactly 1 cycle.
- Latency with tick tied 1: btn_in change before edge k gives level/press high after edge k+1+STABLE_TICKS, i.e. STABLE_TICKS+2 clocks.
- Repeat FSM states (per channel): IDLE, HOLD, REPEAT, with repeat counter rcnt.
  - IDLE -> HOLD: at the edge where level rises; rcnt <= 0.
  - HOLD, tick=1, REPEAT_DELAY>0, rcnt==REPEAT_DELAY-1: repeat_pulse <= 1; rcnt <= 0; -> REPEAT.
  - HOLD, tick=1, otherwise: rcnt++.
  - HOLD, REPEAT_DELAY=0: remains in HOLD and never pulses.
  - REPEAT, tick=1, rcnt==REPEAT_PERIOD-1: repeat_pulse <= 1; rcnt <= 0.
  - REPEAT, tick=1, otherwise: rcnt++.
  - HOLD or REPEAT -> IDLE: at the edge where level falls; rcnt <= 0.
- Simultaneous events:
  - A level fall on the edge a repeat is due suppresses that repeat; release and repeat_pulse are never high together.
  - press and repeat_pulse are never high together, because the first repeat needs >=1 tick after the press.
- Independence: channels are fully independent; the tick input is shared by all channels.
- Arithmetic: counters saturate by construction (compare before increment) and never wrap.

Test Plan:
- Clean press, STABLE_TICKS=4, tick=1, btn_in[0] 0->1 before edge 0 and held:
  - level[0]=1 and press[0]=1 after edge 5;
  - press[0] low again after edge 6;
  - other channels stay 0.
- Glitch rejection: btn_in[1] high for 3 cycles then low, tick=1 -> level, press and release on ch1 remain 0 throughout.
- Auto-repeat, DELAY=8, PERIOD=3, press as in the first scenario:
  - repeat_pulse[0] after edges 13, 16, 19, ...;
  - action[0] high at edges 5, 13, 16, 19.
- Release during repeat: btn_in[0] falls so that level falls at a due-repeat edge -> release=1, no repeat_pulse, FSM in IDLE, no further repeats.
- Tick gating: tick=1 every 4th cycle with STABLE_TICKS=4 -> level changes after exactly 4 ticks (about 16 clocks), never earlier.
- Reset mid-repeat: clear_n=0 for 1 edge while in REPEAT with btn held:
  - all outputs 0 next cycle;
  - the held button re-debounces and produces press after STABLE_TICKS+2 clocks.

Source files
------------

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button pin and conditioned-strobe bundle
interface button_conditioner_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] repeat_pulse;
  logic [N_CH-1:0] action;

  modport master (
    output btn_in,
    input  level, press, release_pulse, repeat_pulse, action
  );

  modport slave (
    input  btn_in,
    output level, press, release_pulse, repeat_pulse, action
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel sync, tick debounce, edge pulses and auto-repeat
module button_conditioner #(
  parameter int N_CH          = 4,
  parameter int STABLE_TICKS  = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 3,
  parameter int ACTIVE_LOW_IN = 0
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 tick,
  button_conditioner_if.slave  bus
);

  localparam int CW   = $clog2(STABLE_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

  logic [N_CH-1:0] pin_w;
  logic [N_CH-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic [N_CH-1:0] rep_q, rep_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [RW-1:0]   rcnt_q [N_CH];
  logic [RW-1:0]   rcnt_d [N_CH];
  state_t          state_q [N_CH];
  state_t          state_d [N_CH];

  // Inversion sits ahead of the sync flops so a cleared flop always reads "not pressed".
  assign pin_w = (ACTIVE_LOW_IN != 0) ? ~bus.btn_in : bus.btn_in;

  always_comb begin
    logic rise, fall;
    s1_d      = pin_w;
    s2_d      = s1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    rep_d     = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      rcnt_d[i]  = rcnt_q[i];
      state_d[i] = state_q[i];
      rise = 1'b0;
      fall = 1'b0;

      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
          level_d[i] = s2_q[i];
          cnt_d[i]   = '0;
          rise       = s2_q[i];
          fall       = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      press_d[i]   = rise;
      release_d[i] = fall;

      // A fall takes priority, so a repeat due on the same edge is dropped.
      case (state_q[i])
        ST_IDLE: begin
          if (rise) begin
            state_d[i] = ST_HOLD;
            rcnt_d[i]  = '0;
          end
        end
        ST_HOLD: begin
          if (fall) begin
            state_d[i] = ST_IDLE;
            rcnt_d[i]  = '0;
          end else if (tick && (REPEAT_DELAY > 0)) begin
            if (rcnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
              rep_d[i]   = 1'b1;
              rcnt_d[i]  = '0;
              state_d[i] = ST_REPEAT;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (fall) begin
            state_d[i] = ST_IDLE;
            rcnt_d[i]  = '0;
          end else if (tick) begin
            if (rcnt_q[i] == RW'(REPEAT_PERIOD - 1)) begin
              rep_d[i]  = 1'b1;
              rcnt_d[i] = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          rcnt_d[i]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      rep_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= '0;
        rcnt_q[i]  <= '0;
        state_q[i] <= ST_IDLE;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      rep_q     <= rep_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign bus.level         = level_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.repeat_pulse  = rep_q;
  assign bus.action        = press_q | rep_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed checks of button_conditioner
module tb_button_conditioner;
  localparam int N  = 4;
  localparam int ST = 4;
  localparam int D  = 8;
  localparam int P  = 3;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic tick = 1'b1;
  always #5 clk = ~clk;

  button_conditioner_if #(.N_CH(N)) bif ();

  button_conditioner #(
    .N_CH(N), .STABLE_TICKS(ST), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .ACTIVE_LOW_IN(0)
  ) dut (
    .clk(clk), .clear_n(clear_n), .tick(tick), .bus(bif.slave)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: sync is a 2-deep delay, debounce counts disagreeing ticks,
  // repeats fall on fixed tick offsets since the press.
  int m_s1 [N];
  int m_s2 [N];
  int m_lvl [N];
  int m_dis [N];
  int m_held [N];
  logic [N-1:0] e_level, e_press, e_rel, e_rep;

  always @(posedge clk) begin
    if (!clear_n) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_dis[i] = 0; m_held[i] = -1;
      end
      e_level = '0; e_press = '0; e_rel = '0; e_rep = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        bit rise, fall, rep;
        rise = 0; fall = 0; rep = 0;
        if (m_s2[i] != m_lvl[i]) begin
          if (tick) begin
            m_dis[i] = m_dis[i] + 1;
            if (m_dis[i] == ST) begin
              m_lvl[i] = m_s2[i];
              m_dis[i] = 0;
              rise = (m_lvl[i] == 1);
              fall = (m_lvl[i] == 0);
            end
          end
        end else begin
          m_dis[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(bif.btn_in[i]);
        if (fall) m_held[i] = -1;
        else if (rise) m_held[i] = 0;
        else if (m_held[i] >= 0 && tick) begin
          m_held[i] = m_held[i] + 1;
          rep = (D > 0) && (m_held[i] >= D) && (((m_held[i] - D) % P) == 0);
        end
        e_level[i] = (m_lvl[i] == 1);
        e_press[i] = rise;
        e_rel[i]   = fall;
        e_rep[i]   = rep;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("level",   bif.level,         e_level);
      chk("press",   bif.press,         e_press);
      chk("release", bif.release_pulse, e_rel);
      chk("repeat",  bif.repeat_pulse,  e_rep);
      chk("action",  bif.action,        e_press | e_rep);
    end
  end

  logic [63:0] act_h, rep_h, rel_h, prs_h;
  logic [N-1:0] oth;
  logic g, early, seen_rep;

  initial begin
    bif.btn_in = '0;
    clear_n = 1'b0;
    tick = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_level",   bif.level, 0);
    chk("rst_press",   bif.press, 0);
    chk("rst_release", bif.release_pulse, 0);
    chk("rst_repeat",  bif.repeat_pulse, 0);
    chk("rst_action",  bif.action, 0);

    // Clean press on ch0, held into repeat, released so the fall lands on a due repeat.
    clear_n = 1'b1;
    bif.btn_in[0] = 1'b1;
    act_h = '0; rep_h = '0; rel_h = '0; prs_h = '0; oth = '0;
    for (int e = 0; e < 36; e++) begin
      @(negedge clk);
      act_h[e] = bif.action[0];
      rep_h[e] = bif.repeat_pulse[0];
      rel_h[e] = bif.release_pulse[0];
      prs_h[e] = bif.press[0];
      oth = oth | (bif.level & 4'b1110);
      if (e == 4) chk("lvl_edge4", bif.level[0], 0);
      if (e == 5) chk("lvl_edge5", bif.level[0], 1);
      if (e == 19) bif.btn_in[0] = 1'b0;
    end
    chk("press_hist",   prs_h, 64'd1 << 5);
    chk("action_hist",  act_h, (64'd1 << 5) | (64'd1 << 13) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22));
    chk("repeat_hist",  rep_h, (64'd1 << 13) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22));
    chk("release_hist", rel_h, 64'd1 << 25);
    chk("other_ch",     oth, 0);

    // Three-cycle glitch on ch1.
    g = 1'b0;
    bif.btn_in[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 2) bif.btn_in[1] = 1'b0;
      g = g | bif.level[1] | bif.press[1] | bif.release_pulse[1];
    end
    chk("glitch_ch1", g, 0);

    // Sparse tick on ch2: one tick every 4th clock.
    early = 1'b0;
    bif.btn_in[2] = 1'b1;
    for (int n = 0; n < 16; n++) begin
      tick = ((n % 4) == 3);
      @(negedge clk);
      if (n < 15) early = early | bif.level[2];
      if (n == 15) chk("tick_lvl_edge15", bif.level[2], 1);
    end
    chk("tick_no_early", early, 0);

    // Hold ch2 into REPEAT, then reset for a single edge.
    tick = 1'b1;
    seen_rep = 1'b0;
    repeat (14) begin
      @(negedge clk);
      seen_rep = seen_rep | bif.repeat_pulse[2];
    end
    chk("ch2_repeating", seen_rep, 1);
    clear_n = 1'b0;
    @(negedge clk);
    chk("midrep_rst_level",  bif.level, 0);
    chk("midrep_rst_action", bif.action, 0);
    chk("midrep_rst_repeat", bif.repeat_pulse, 0);
    clear_n = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 5) chk("rearm_press_j5", bif.press[2], 0);
      if (j == 6) chk("rearm_press_j6", bif.press[2], 1);
    end

    // Random phase: slow button toggles, random tick, rare resets.
    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom_range(0, 3) != 0);
      clear_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 39) == 0) bif.btn_in[i] = ~bif.btn_in[i];
      if ($urandom_range(0, 60) == 0) bif.btn_in[3] = ~bif.btn_in[3];
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
